// File: rtl/user_interval_monitor_pkg.sv
// user_interval_monitor_pkg: shared types, latency constant and edge-match helper for the interval monitors
package user_interval_monitor_pkg;
  typedef enum logic [1:0] {
    EDGE_BOTH    = 2'd0,
    EDGE_RISING  = 2'd1,
    EDGE_FALLING = 2'd2,
    EDGE_NONE    = 2'd3
  } edge_mode_t;

  localparam int LATENCY = 5;

  typedef struct packed {
    logic [63:0] tagtime;
    logic [4:0]  channel;
    logic        rising_edge;
  } tag_lane_t;

  function automatic logic edge_match(input edge_mode_t mode, input logic rising);
    return mode == EDGE_BOTH || (mode == EDGE_RISING && rising) || (mode == EDGE_FALLING && !rising);
  endfunction
endpackage

// File: rtl/interval_monitor_lane_chain.sv
// interval_monitor_lane_chain: one monitor's match, pairing, diff, window check and status pipeline
module interval_monitor_lane_chain
  import user_interval_monitor_pkg::*;
#(
  parameter int WORD_WIDTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  input  tag_lane_t [WORD_WIDTH-1:0]  i_lanes,
  input  logic [WORD_WIDTH-1:0]       i_keep,
  input  logic                        i_enable,
  input  logic [4:0]                  i_channel,
  input  edge_mode_t                  i_edge_mode,
  input  logic [63:0]                 i_lower,
  input  logic [63:0]                 i_upper,
  input  logic                        i_clear,
  output logic [CNT_WIDTH-1:0]        o_viol_cnt,
  output logic [63:0]                 o_last_diff,
  output logic [63:0]                 o_first_time,
  output logic                        o_failed
);
  localparam int KW  = $clog2(WORD_WIDTH + 1);
  localparam int CW1 = CNT_WIDTH + 1;

  logic [WORD_WIDTH-1:0]       w_match, w_pair, w_err;
  logic [WORD_WIDTH-1:0]       r_s1_match, r_s2_pair, r_s3_pair, r_s4_err;
  logic [WORD_WIDTH-1:0][63:0] w_prev;
  logic [WORD_WIDTH-1:0][63:0] r_s1_time, r_s2_tag, r_s2_prev, r_s3_tag, r_s3_diff, r_s4_tag, r_s4_diff;
  logic                        w_cv, r_carry_valid;
  logic [63:0]                 w_ct, r_carry_time;
  logic [KW-1:0]               w_k;
  logic [63:0]                 w_hi_diff, w_lo_time;
  logic [CW1-1:0]              w_sum;
  logic [CNT_WIDTH-1:0]        w_sat, r_viol_cnt;
  logic [63:0]                 r_last_diff, r_first_time;
  logic                        r_failed;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < WORD_WIDTH; i++)
      w_match[i] = i_valid && i_keep[i] && i_enable && i_lanes[i].channel == i_channel
                   && edge_match(i_edge_mode, i_lanes[i].rising_edge);
  end

  // Lane walk: each matching lane pairs with the most recent earlier match, possibly from a prior word
  always_comb begin
    w_cv   = r_carry_valid;
    w_ct   = r_carry_time;
    w_pair = '0;
    w_prev = '0;
    for (int i = 0; i < WORD_WIDTH; i++)
      if (r_s1_match[i]) begin
        w_pair[i] = w_cv;
        w_prev[i] = w_ct;
        w_cv      = 1'b1;
        w_ct      = r_s1_time[i];
      end
  end

  always_comb begin
    w_err = '0;
    for (int i = 0; i < WORD_WIDTH; i++)
      w_err[i] = r_s3_pair[i] && (r_s3_diff[i] < i_lower || r_s3_diff[i] > i_upper);
  end

  always_comb begin
    w_k       = '0;
    w_hi_diff = '0;
    w_lo_time = '0;
    for (int i = WORD_WIDTH - 1; i >= 0; i--)
      if (r_s4_err[i]) begin
        w_k       = w_k + KW'(1);
        w_lo_time = r_s4_tag[i];
      end
    for (int i = 0; i < WORD_WIDTH; i++)
      if (r_s4_err[i]) w_hi_diff = r_s4_diff[i];
    w_sum = {1'b0, r_viol_cnt} + CW1'(w_k);
    w_sat = w_sum[CNT_WIDTH] ? '1 : w_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_s1_match    <= '0;
      r_s1_time     <= '0;
      r_s2_pair     <= '0;
      r_s2_tag      <= '0;
      r_s2_prev     <= '0;
      r_s3_pair     <= '0;
      r_s3_tag      <= '0;
      r_s3_diff     <= '0;
      r_s4_err      <= '0;
      r_s4_tag      <= '0;
      r_s4_diff     <= '0;
      r_carry_valid <= 1'b0;
      r_carry_time  <= '0;
      r_viol_cnt    <= '0;
      r_last_diff   <= '0;
      r_first_time  <= '0;
      r_failed      <= 1'b0;
    end else begin
      r_s1_match    <= w_match;
      for (int i = 0; i < WORD_WIDTH; i++) r_s1_time[i] <= i_lanes[i].tagtime;
      r_s2_pair     <= w_pair;
      r_s2_tag      <= r_s1_time;
      r_s2_prev     <= w_prev;
      r_carry_valid <= w_cv;
      r_carry_time  <= w_ct;
      r_s3_pair     <= r_s2_pair;
      r_s3_tag      <= r_s2_tag;
      for (int i = 0; i < WORD_WIDTH; i++) r_s3_diff[i] <= r_s2_tag[i] - r_s2_prev[i];
      r_s4_err      <= w_err;
      r_s4_tag      <= r_s3_tag;
      r_s4_diff     <= r_s3_diff;
      if (|r_s4_err) begin
        r_viol_cnt  <= w_sat;
        r_last_diff <= w_hi_diff;
        if (!r_failed) r_first_time <= w_lo_time;
        r_failed    <= 1'b1;
      end
    end
  end

  assign o_viol_cnt   = r_viol_cnt;
  assign o_last_diff  = r_last_diff;
  assign o_first_time = r_first_time;
  assign o_failed     = r_failed;
endmodule

// File: rtl/user_interval_monitor.sv
// user_interval_monitor: NUM_MONITORS independent tag-interval window checkers on one sorted tag stream
module user_interval_monitor
  import user_interval_monitor_pkg::*;
#(
  parameter int WORD_WIDTH   = 4,
  parameter int NUM_MONITORS = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_axis_tvalid,
  output logic                                   s_axis_tready,
  input  logic [WORD_WIDTH-1:0][63:0]            s_axis_tagtime,
  input  logic [WORD_WIDTH-1:0][4:0]             s_axis_channel,
  input  logic [WORD_WIDTH-1:0]                  s_axis_rising_edge,
  input  logic [WORD_WIDTH-1:0]                  s_axis_tkeep,
  input  logic [NUM_MONITORS-1:0]                cfg_enable,
  input  logic [NUM_MONITORS-1:0][4:0]           cfg_channel,
  input  logic [NUM_MONITORS-1:0][1:0]           cfg_edge_mode,
  input  logic [NUM_MONITORS-1:0][63:0]          cfg_lower,
  input  logic [NUM_MONITORS-1:0][63:0]          cfg_upper,
  input  logic [NUM_MONITORS-1:0]                mon_clear,
  output logic [NUM_MONITORS-1:0][CNT_WIDTH-1:0] stat_viol_cnt,
  output logic [NUM_MONITORS-1:0][63:0]          stat_last_diff,
  output logic [NUM_MONITORS-1:0][63:0]          stat_first_time,
  output logic [NUM_MONITORS-1:0]                stat_failed,
  output logic                                   any_failed
);
  tag_lane_t [WORD_WIDTH-1:0] w_lanes;
  logic                       r_any_failed;

  assign s_axis_tready = 1'b1;

  always_comb begin
    w_lanes = '0;
    for (int i = 0; i < WORD_WIDTH; i++)
      w_lanes[i] = '{tagtime: s_axis_tagtime[i], channel: s_axis_channel[i], rising_edge: s_axis_rising_edge[i]};
  end

  for (genvar g = 0; g < NUM_MONITORS; g++) begin : g_mon
    interval_monitor_lane_chain #(
      .WORD_WIDTH (WORD_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_chain (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (s_axis_tvalid),
      .i_lanes      (w_lanes),
      .i_keep       (s_axis_tkeep),
      .i_enable     (cfg_enable[g]),
      .i_channel    (cfg_channel[g]),
      .i_edge_mode  (edge_mode_t'(cfg_edge_mode[g])),
      .i_lower      (cfg_lower[g]),
      .i_upper      (cfg_upper[g]),
      .i_clear      (mon_clear[g]),
      .o_viol_cnt   (stat_viol_cnt[g]),
      .o_last_diff  (stat_last_diff[g]),
      .o_first_time (stat_first_time[g]),
      .o_failed     (stat_failed[g])
    );
  end

  always_ff @(posedge clk) r_any_failed <= rst ? 1'b0 : |stat_failed;

  assign any_failed = r_any_failed;
endmodule

// File: tb/tb_user_interval_monitor.sv
// tb_user_interval_monitor: directed-vector check of windowing, saturation, clear and reset behaviour
module tb_user_interval_monitor;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tready;
  logic [3:0][63:0] s_axis_tagtime = '0;
  logic [3:0][4:0]  s_axis_channel = '0;
  logic [3:0]       s_axis_rising_edge = '0;
  logic [3:0]       s_axis_tkeep = '0;
  logic [3:0]       cfg_enable = '0;
  logic [3:0][4:0]  cfg_channel = '0;
  logic [3:0][1:0]  cfg_edge_mode = '0;
  logic [3:0][63:0] cfg_lower = '0;
  logic [3:0][63:0] cfg_upper = '0;
  logic [3:0]       mon_clear = '0;
  logic [3:0][3:0]  stat_viol_cnt;
  logic [3:0][63:0] stat_last_diff;
  logic [3:0][63:0] stat_first_time;
  logic [3:0]       stat_failed;
  logic             any_failed;
  int               n_tests = 0;
  int               n_fail = 0;

  always #5 clk = ~clk;

  user_interval_monitor #(.WORD_WIDTH(4), .NUM_MONITORS(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tagtime(s_axis_tagtime), .s_axis_channel(s_axis_channel),
    .s_axis_rising_edge(s_axis_rising_edge), .s_axis_tkeep(s_axis_tkeep),
    .cfg_enable(cfg_enable), .cfg_channel(cfg_channel), .cfg_edge_mode(cfg_edge_mode),
    .cfg_lower(cfg_lower), .cfg_upper(cfg_upper), .mon_clear(mon_clear),
    .stat_viol_cnt(stat_viol_cnt), .stat_last_diff(stat_last_diff),
    .stat_first_time(stat_first_time), .stat_failed(stat_failed), .any_failed(any_failed)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic [63:0] t, input logic [4:0] c, input logic r);
    s_axis_tagtime[i]     = t;
    s_axis_channel[i]     = c;
    s_axis_rising_edge[i] = r;
    s_axis_tkeep[i]       = 1'b1;
  endtask

  task automatic push();
    s_axis_tvalid = 1'b1;
    idle(1);
    s_axis_tvalid = 1'b0;
    s_axis_tkeep  = '0;
  endtask

  initial begin
    cfg_enable    = 4'b0111;
    cfg_channel[0] = 5'd2; cfg_edge_mode[0] = 2'd0; cfg_lower[0] = 100; cfg_upper[0] = 200;
    cfg_channel[1] = 5'd0; cfg_edge_mode[1] = 2'd1; cfg_lower[1] = 10;  cfg_upper[1] = 10;
    cfg_channel[2] = 5'd3; cfg_edge_mode[2] = 2'd0; cfg_lower[2] = 1;   cfg_upper[2] = 0;
    idle(3);
    chk("tready_in_reset", s_axis_tready, 1);
    rst = 1'b0;
    idle(1);
    chk("rst_cnt0", stat_viol_cnt[0], 0);
    chk("rst_failed", stat_failed, 0);
    chk("rst_any", any_failed, 0);

    put(0, 1000, 2, 1); put(1, 1150, 2, 0); put(2, 1300, 2, 1);
    push();
    idle(4);
    chk("in_window_cnt", stat_viol_cnt[0], 0);
    chk("in_window_failed", stat_failed[0], 0);

    put(0, 1600, 2, 1);
    push();
    idle(3);
    chk("latency_n4_cnt", stat_viol_cnt[0], 0);
    idle(1);
    chk("cross_word_cnt", stat_viol_cnt[0], 1);
    chk("cross_word_last", stat_last_diff[0], 300);
    chk("cross_word_first", stat_first_time[0], 1600);
    chk("cross_word_failed", stat_failed[0], 1);
    chk("any_n5", any_failed, 0);
    idle(1);
    chk("any_n6", any_failed, 1);

    put(0, 0, 0, 1); put(1, 5, 0, 0); put(2, 10, 0, 1); put(3, 25, 0, 1);
    push();
    idle(4);
    chk("rising_cnt", stat_viol_cnt[1], 1);
    chk("rising_last", stat_last_diff[1], 15);
    chk("rising_first", stat_first_time[1], 25);

    for (int i = 0; i < 4; i++) put(i, 64'(5000 + 7 * i), 3, 1);
    push();
    idle(4);
    chk("inv_bounds_cnt", stat_viol_cnt[2], 3);
    chk("inv_bounds_first", stat_first_time[2], 5007);
    for (int w = 1; w < 5; w++) begin
      for (int i = 0; i < 4; i++) put(i, 64'(5000 + 7 * (4 * w + i)), 3, 1);
      push();
    end
    idle(4);
    chk("sat_cnt", stat_viol_cnt[2], 15);
    chk("sat_failed", stat_failed[2], 1);
    chk("sat_last", stat_last_diff[2], 7);
    chk("sat_first_held", stat_first_time[2], 5007);

    put(0, 2000, 2, 1); push();
    put(0, 2500, 2, 1); push();
    put(0, 3000, 2, 1); push();
    mon_clear = 4'b0001;
    idle(1);
    mon_clear = 4'b0000;
    idle(6);
    chk("clr_cnt", stat_viol_cnt[0], 0);
    chk("clr_failed", stat_failed[0], 0);
    chk("clr_last", stat_last_diff[0], 0);
    chk("clr_first", stat_first_time[0], 0);
    chk("clr_m1_cnt", stat_viol_cnt[1], 1);
    chk("clr_m1_last", stat_last_diff[1], 15);
    chk("clr_any", any_failed, 1);
    put(0, 4000, 2, 1); push();
    put(0, 4100, 2, 1); push();
    idle(4);
    chk("fresh_hist_cnt", stat_viol_cnt[0], 0);

    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("mid_rst_cnt%0d", m), stat_viol_cnt[m], 0);
      chk($sformatf("mid_rst_last%0d", m), stat_last_diff[m], 0);
      chk($sformatf("mid_rst_first%0d", m), stat_first_time[m], 0);
    end
    chk("mid_rst_failed", stat_failed, 0);
    chk("mid_rst_any", any_failed, 0);
    put(0, 9000, 2, 1); push();
    idle(4);
    chk("post_rst_first_tag", stat_viol_cnt[0], 0);
    put(0, 9500, 2, 1); push();
    idle(4);
    chk("post_rst_cnt", stat_viol_cnt[0], 1);
    chk("post_rst_last", stat_last_diff[0], 500);
    chk("post_rst_first", stat_first_time[0], 9500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/user_interval_monitor.md
Name: user_interval_monitor

Overview:
Multi-monitor successor to the single-channel tag-interval checker. It holds NUM_MONITORS independent monitors. Each monitor watches one selectable channel and edge polarity in the sorted tag stream, computes the time between consecutive matching tags (including across words), and checks it against that monitor's inclusive [lower, upper] window. Per monitor it reports a violation count, the last failing interval and the timestamp of the first failure. It sits beside the user sample logic on the tag stream; configuration and status are same-clock ports, and any bus bridging happens outside the block.

Parameters:
WORD_WIDTH, 4, tag lanes per stream word
NUM_MONITORS, 4, number of independent interval monitors (1..16)
CNT_WIDTH, 32, width of each saturating violation counter

Ports:
clk  in  1  stream and logic clock
rst  in  1  synchronous, active-high reset
s_axis_tvalid  in  1  word valid
s_axis_tready  out  1  constant 1
s_axis_tagtime  in  64 x WORD_WIDTH  tag time, 1/3 ps units
s_axis_channel  in  5 x WORD_WIDTH  zero-based channel
s_axis_rising_edge  in  1 x WORD_WIDTH  1 = rising edge
s_axis_tkeep  in  WORD_WIDTH  per-lane event valid
cfg_enable  in  1 x NUM_MONITORS  monitor enabled
cfg_channel  in  5 x NUM_MONITORS  channel to watch
cfg_edge_mode  in  2 x NUM_MONITORS  0 = both edges, 1 = rising, 2 = falling, 3 = none
cfg_lower  in  64 x NUM_MONITORS  inclusive lower bound
cfg_upper  in  64 x NUM_MONITORS  inclusive upper bound
mon_clear  in  1 x NUM_MONITORS  one-cycle pulse that clears that monitor
stat_viol_cnt  out  CNT_WIDTH x NUM_MONITORS  saturating violation count
stat_last_diff  out  64 x NUM_MONITORS  most recent failing interval
stat_first_time  out  64 x NUM_MONITORS  tagtime of first failing event since clear
stat_failed  out  1 x NUM_MONITORS  sticky failure flag
any_failed  out  1  OR of stat_failed

Behaviour:
- rst: all stat_* outputs are 0, any_failed is 0, every pipeline valid bit is 0, and every monitor has no previous tag. s_axis_tready is 1 even during reset; words arriving during reset are dropped.
- Lane match for monitor m: tvalid && tkeep[i] && cfg_enable[m] && channel[i] == cfg_channel[m] && the edge matches cfg_edge_mode[m].
- Pipeline per monitor:
  - S1: register the lane match and tagtime.
  - S2: walk lanes 0..WORD_WIDTH-1 in order, muxing in the previous matching tag; the carry register persists across words.
  - S3: diff = tag - prev, modulo 2^64.
  - S4: err = pair valid && (diff < cfg_lower || diff > cfg_upper), unsigned.
  - S5: update status.
- Latency: a word accepted at cycle N is reflected in stat_* at N+5, and in any_failed at N+6 (registered OR).
- The first matching tag after reset or clear produces no interval.
- S5 update when a word has k ≥ 1 failing lanes:
  - viol_cnt += k, saturating at 2^CNT_WIDTH-1 with no wrap.
  - last_diff is taken from the highest failing lane.
  - If stat_failed was 0, first_time is the tagtime of the lowest failing lane.
  - stat_failed is set to 1.
- mon_clear[m] at cycle C:
  - zeroes monitor m's status and carry register.
  - invalidates monitor m's S1–S5 contents at C+1.
  - Tags accepted at C are discarded; tags accepted at C+1 start a fresh history.
  - Other monitors are unaffected.
  - Clear has priority over an S5 update in the same cycle.
- cfg_enable low: new tags do not match. The carry register and the status are held. Re-enabling resumes with the old previous tag; issue a clear to avoid a stale interval.
- cfg_lower and cfg_upper are sampled in S4. cfg_channel and cfg_edge_mode are sampled in S1. Software changes these only while the monitor is disabled.
- cfg_lower > cfg_upper: every interval fails.
- diff of 0 (equal timestamps) is a legal interval.
- Sorted input is guaranteed, so modular wrap is not treated as an error case.

Decomposition:
- user_interval_monitor_pkg holds:
  - edge_mode_t enum (BOTH, RISING, FALLING, NONE)
  - LATENCY = 5
  - a tag lane struct {tagtime, channel, rising_edge}
- Sub-module interval_monitor_lane_chain holds one monitor's S1–S5 chain. The top module instantiates it with a generate loop over NUM_MONITORS and builds the any_failed OR.

Test Plan:
- Monitor 0: ch2, both edges, bounds [100, 200]. Ch2 tags at 1000, 1150, 1300 in one word -> no failure, viol_cnt 0.
- Same setup, next word has a ch2 tag at 1600 (interval 300, across the word boundary) -> viol_cnt 1, last_diff 300, first_time 1600, stat_failed 1, all at +5 cycles.
- Monitor 1: ch0, rising, bounds [10, 10]. Lanes: rise 0, fall 5, rise 10, rise 25 -> the falling tag is ignored; count 1, last_diff 15, first_time 25.
- CNT_WIDTH = 4, bounds [1, 0], 20 matching tags -> count saturates at 15 and stat_failed stays 1.
- mon_clear[0] pulsed while 3 failing words are in flight -> monitor 0 status 0 afterwards, the in-flight failures are not counted, and monitor 1 counters are unchanged.
- rst asserted mid-stream for 1 cycle -> all stat_* and any_failed are 0; the next tag gives no interval, and the following tag compares only against it.
